feature_extractor: RTL and testbench

- Front end of the driver-monitor datapath. It accepts raw sensor samples and produces the four signed/unsigned feature operands (accel, jerk, steer, brake) that the weighted-score pipeline consumes.
- Accel is smoothed with a moving-average filter. Jerk is the sample-to-sample difference of the filtered accel.
- Brake is clamped so the downstream multiply stays in range.
- A warm-up counter and an idle timeout qualify the features with feat_valid and stale.

---
 rtl/dm_pkg.sv | 27 ++
 rtl/feature_extractor_if.sv | 43 ++++
 rtl/feature_extractor_accel_mavg.sv | 53 +++++
 rtl/feature_extractor.sv | 111 +++++++++++
 tb/tb_feature_extractor.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared constants, types and helpers for the driver-monitor front end.
// Feature width, default tuning values and jerk saturation.
package dm_pkg;

  localparam int FEAT_W        = 8;
  localparam int WIN_LOG2_DEF  = 2;
  localparam int TIMEOUT_DEF   = 1000;
  localparam int BRAKE_MAX_DEF = 127;

  typedef logic signed [FEAT_W-1:0] feat_t;

  // Narrow a 9-bit signed difference to the 8-bit feature range.
  function automatic feat_t sat8(
    input logic signed [FEAT_W:0] v
  );
    feat_t r;
    if (v > 9'sd127) begin
      r = 8'sd127;
    end else if (v < -9'sd128) begin
      r = -8'sd128;
    end else begin
      r = v[FEAT_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/feature_extractor_if.sv
// Sample-in / feature-out bundle of the feature extractor.
// The master drives raw samples; the slave returns features.
interface feature_extractor_if;
  import dm_pkg::*;

  logic              sample_valid;
  logic [FEAT_W-1:0] accel_raw;
  logic [FEAT_W-1:0] steer_raw;
  logic [FEAT_W-1:0] brake_raw;
  logic [FEAT_W-1:0] accel;
  logic [FEAT_W-1:0] jerk;
  logic [FEAT_W-1:0] steer;
  logic [FEAT_W-1:0] brake;
  logic              feat_valid;
  logic              stale;

  modport master (
    output sample_valid,
    output accel_raw,
    output steer_raw,
    output brake_raw,
    input  accel,
    input  jerk,
    input  steer,
    input  brake,
    input  feat_valid,
    input  stale
  );

  modport slave (
    input  sample_valid,
    input  accel_raw,
    input  steer_raw,
    input  brake_raw,
    output accel,
    output jerk,
    output steer,
    output brake,
    output feat_valid,
    output stale
  );

endinterface

// File: rtl/feature_extractor_accel_mavg.sv
// Moving-average filter for the accel feature.
// Window shift register, running sum and floor-shift average.
module accel_mavg
  import dm_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  flush,
  input  feat_t din,
  output feat_t avg
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int SW  = FEAT_W + WIN_LOG2;

  feat_t                win_q [WIN];
  logic signed [SW-1:0] sum_q;
  logic signed [SW-1:0] sum_next;

  // Running sum with the new sample in and the oldest out; the
  // arithmetic shift floors toward negative infinity.
  always_comb begin
    sum_next = sum_q
             + SW'(din)
             - SW'(win_q[WIN-1]);
    avg = feat_t'(sum_next >>> WIN_LOG2);
  end

  // Window and sum update; a flush empties the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
    end else if (flush) begin
      sum_q <= '0;
      for (int i = 0; i < WIN; i++) begin
        win_q[i] <= '0;
      end
    end else if (en) begin
      sum_q    <= sum_next;
      win_q[0] <= din;
      for (int i = 1; i < WIN; i++) begin
        win_q[i] <= win_q[i-1];
      end
    end
  end

endmodule

// File: rtl/feature_extractor.sv
// Driver-monitor front end: filtered accel, jerk, steer and
// clamped brake, qualified by warm-up and idle timeout.
module feature_extractor
  import dm_pkg::*;
#(
  parameter int WIN_LOG2  = WIN_LOG2_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int BRAKE_MAX = BRAKE_MAX_DEF
) (
  input logic               clk,
  input logic               rst,
  feature_extractor_if.slave bus
);

  localparam int WIN = 1 << WIN_LOG2;
  localparam int CW  = $clog2(WIN + 1);
  localparam int IW  = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] WIN_C = CW'(WIN);
  localparam logic [IW-1:0] TO_C  = IW'(TIMEOUT);
  localparam logic [IW-1:0] TO_M1 = IW'(TIMEOUT - 1);
  localparam logic [FEAT_W-1:0] BMAX = FEAT_W'(BRAKE_MAX);

  feat_t             avg;
  feat_t             avg_prev_q;
  feat_t             accel_q;
  feat_t             jerk_q;
  feat_t             steer_q;
  feat_t             jerk_sat;
  logic [FEAT_W-1:0] brake_q;
  logic [FEAT_W-1:0] brake_clamp;
  logic signed [FEAT_W:0] jerk_raw;
  logic              fv_q;
  logic              stale_q;
  logic [CW-1:0]     warm_q;
  logic [IW-1:0]     idle_q;
  logic              take;
  logic              flush;

  accel_mavg #(
    .WIN_LOG2 (WIN_LOG2)
  ) u_mavg (
    .clk   (clk),
    .rst   (rst),
    .en    (take),
    .flush (flush),
    .din   (feat_t'(bus.accel_raw)),
    .avg   (avg)
  );

  // Sample strobe, timeout detect, jerk and brake shaping.
  // A sample in the would-be timeout cycle suppresses the flush.
  always_comb begin
    take        = bus.sample_valid;
    flush       = !take && (idle_q == TO_M1);
    jerk_raw    = (FEAT_W+1)'(avg)
                - (FEAT_W+1)'(avg_prev_q);
    jerk_sat    = sat8(jerk_raw);
    brake_clamp = (bus.brake_raw > BMAX)
                ? BMAX : bus.brake_raw;
  end

  // Feature registers, warm-up count and idle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accel_q    <= '0;
      jerk_q     <= '0;
      steer_q    <= '0;
      brake_q    <= '0;
      fv_q       <= 1'b0;
      stale_q    <= 1'b0;
      avg_prev_q <= '0;
      warm_q     <= '0;
      idle_q     <= '0;
    end else if (take) begin
      accel_q    <= avg;
      jerk_q     <= jerk_sat;
      steer_q    <= feat_t'(bus.steer_raw);
      brake_q    <= brake_clamp;
      fv_q       <= (warm_q == WIN_C);
      stale_q    <= 1'b0;
      avg_prev_q <= avg;
      idle_q     <= '0;
      if (warm_q != WIN_C) begin
        warm_q <= warm_q + CW'(1);
      end
    end else begin
      fv_q <= 1'b0;
      if (idle_q != TO_C) begin
        idle_q <= idle_q + IW'(1);
      end
      if (flush) begin
        accel_q    <= '0;
        jerk_q     <= '0;
        steer_q    <= '0;
        brake_q    <= '0;
        avg_prev_q <= '0;
        warm_q     <= '0;
        stale_q    <= 1'b1;
      end
    end
  end

  assign bus.accel      = accel_q;
  assign bus.jerk       = jerk_q;
  assign bus.steer      = steer_q;
  assign bus.brake      = brake_q;
  assign bus.feat_valid = fv_q;
  assign bus.stale      = stale_q;

endmodule

// File: tb/tb_feature_extractor.sv
// Scoreboard bench for feature_extractor: two instances
// (window 4 / timeout 16, and window 1) against a reference model.
module tb_feature_extractor;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  feature_extractor_if if0 ();
  feature_extractor_if if1 ();

  feature_extractor #(
    .WIN_LOG2 (2), .TIMEOUT (16), .BRAKE_MAX (127)
  ) dut0 (.clk (clk), .rst (rst), .bus (if0));

  feature_extractor #(
    .WIN_LOG2 (0), .TIMEOUT (1000), .BRAKE_MAX (127)
  ) dut1 (.clk (clk), .rst (rst), .bus (if1));

  typedef struct packed {
    logic [7:0] accel;
    logic [7:0] jerk;
    logic [7:0] steer;
    logic [7:0] brake;
    logic       fv;
    logic       stale;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t cur[2];
  int   hist0[$];
  int   hist1[$];
  int   prev[2];
  int   nacc[2];
  int   idle[2];
  int   checks   = 0;
  int   failures = 0;

  function automatic int floor_div(int s, int w);
    if (s >= 0) return s / w;
    return -((-s + w - 1) / w);
  endfunction

  function automatic int win_sum(input int h[$], input int w);
    int s = 0;
    for (int k = 0; k < w && k < h.size(); k++) s += h[h.size()-1-k];
    return s;
  endfunction

  function automatic int clamp(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_reset();
    for (int id = 0; id < 2; id++) begin
      cur[id]  = '0;
      prev[id] = 0;
      nacc[id] = 0;
      idle[id] = 0;
    end
    hist0.delete();
    hist1.delete();
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step(int id, bit v, int a, int s, int b);
    int w;
    int to;
    int sm;
    int avg;
    w  = (id == 0) ? 4 : 1;
    to = (id == 0) ? 16 : 1000;
    if (v) begin
      if (id == 0) begin
        hist0.push_back(a);
        if (hist0.size() > 8) void'(hist0.pop_front());
        sm = win_sum(hist0, w);
      end else begin
        hist1.push_back(a);
        if (hist1.size() > 8) void'(hist1.pop_front());
        sm = win_sum(hist1, w);
      end
      avg = floor_div(sm, w);
      cur[id].accel = 8'(avg);
      cur[id].jerk  = 8'(clamp(avg - prev[id], -128, 127));
      cur[id].steer = 8'(s);
      cur[id].brake = 8'((b > 127) ? 127 : b);
      cur[id].fv    = (nacc[id] >= w);
      cur[id].stale = 1'b0;
      nacc[id]++;
      prev[id] = avg;
      idle[id] = 0;
    end else begin
      cur[id].fv = 1'b0;
      if (idle[id] < to) begin
        idle[id]++;
        if (idle[id] == to) begin
          cur[id]       = '0;
          cur[id].stale = 1'b1;
          prev[id]      = 0;
          nacc[id]      = 0;
          if (id == 0) hist0.delete();
          else         hist1.delete();
        end
      end
    end
    if (id == 0) q0.push_back(cur[id]);
    else         q1.push_back(cur[id]);
  endtask

  task automatic set_inputs(bit v, int a, int s, int b);
    if0.sample_valid = v;
    if0.accel_raw    = 8'(a);
    if0.steer_raw    = 8'(s);
    if0.brake_raw    = 8'(b);
    if1.sample_valid = v;
    if1.accel_raw    = 8'(a);
    if1.steer_raw    = 8'(s);
    if1.brake_raw    = 8'(b);
  endtask

  task automatic apply(bit v, int a, int s, int b);
    set_inputs(v, a, s, b);
    model_step(0, v, a, s, b);
    model_step(1, v, a, s, b);
  endtask

  task automatic drive(bit v, int a, int s, int b);
    @(negedge clk);
    apply(v, a, s, b);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic mon_cmp(int id);
    exp_t a;
    exp_t e;
    if (id == 0)
      a = {if0.accel, if0.jerk, if0.steer, if0.brake,
           if0.feat_valid, if0.stale};
    else
      a = {if1.accel, if1.jerk, if1.steer, if1.brake,
           if1.feat_valid, if1.stale};
    checks++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      failures++;
      $display("FAIL sb%0d underflow at %0t", id, $time);
      return;
    end
    e = (id == 0) ? q0.pop_front() : q1.pop_front();
    if (a !== e) begin
      failures++;
      $display("FAIL sb%0d t=%0t actual acc=%h jrk=%h str=%h brk=%h fv=%b st=%b required acc=%h jrk=%h str=%h brk=%h fv=%b st=%b",
               id, $time, a.accel, a.jerk, a.steer, a.brake, a.fv, a.stale,
               e.accel, e.jerk, e.steer, e.brake, e.fv, e.stale);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      mon_cmp(0);
      mon_cmp(1);
    end
  end

  initial begin
    int acc_e[5];
    int jrk_e[5];
    set_inputs(0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_accel", if0.accel, 8'h00);
    chk("rst_jerk", if0.jerk, 8'h00);
    chk("rst_brake", if0.brake, 8'h00);
    chk("rst_fv", {7'b0, if0.feat_valid}, 8'h00);
    chk("rst_stale", {7'b0, if0.stale}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 0);

    acc_e = '{2, 4, 6, 8, 8};
    for (int i = 0; i < 5; i++) begin
      drive(1, 8, 0, 0);
      settle();
      chk("warm_accel", if0.accel, 8'(acc_e[i]));
      chk("warm_fv", {7'b0, if0.feat_valid}, (i == 4) ? 8'h01 : 8'h00);
    end
    chk("warm_jerk", if0.jerk, 8'h00);

    repeat (5) drive(1, 0, 0, 0);
    acc_e = '{25, 50, 75, 100, 100};
    jrk_e = '{25, 25, 25, 25, 0};
    for (int i = 0; i < 5; i++) begin
      drive(1, 100, 0, 0);
      settle();
      chk("step_accel", if0.accel, 8'(acc_e[i]));
      chk("step_jerk", if0.jerk, 8'(jrk_e[i]));
      chk("step_fv", {7'b0, if0.feat_valid}, 8'h01);
    end

    drive(1, -128, 0, 0);
    drive(1, 127, 0, 0);
    settle();
    chk("w1_accel", if1.accel, 8'h7f);
    chk("w1_jerk_pos", if1.jerk, 8'h7f);
    drive(1, -128, 0, 0);
    settle();
    chk("w1_jerk_neg", if1.jerk, 8'h80);

    drive(1, 0, -45, 200);
    settle();
    chk("brake_clamp", if0.brake, 8'h7f);
    chk("steer_pass", if0.steer, 8'hd3);
    drive(1, 0, 0, 90);
    settle();
    chk("brake_pass", if0.brake, 8'h5a);

    repeat (15) drive(0, 0, 0, 0);
    settle();
    chk("pre_to_stale", {7'b0, if0.stale}, 8'h00);
    drive(0, 0, 0, 0);
    settle();
    chk("to_stale", {7'b0, if0.stale}, 8'h01);
    chk("to_accel", if0.accel, 8'h00);
    chk("to_steer", if0.steer, 8'h00);
    chk("to_brake", if0.brake, 8'h00);
    for (int i = 0; i < 5; i++) begin
      drive(1, 20, 3, 50);
      settle();
      chk("post_to_fv", {7'b0, if0.feat_valid}, (i == 4) ? 8'h01 : 8'h00);
      chk("post_to_stale", {7'b0, if0.stale}, 8'h00);
    end
    repeat (15) drive(0, 0, 0, 0);
    drive(1, 20, 3, 50);
    settle();
    chk("race_stale", {7'b0, if0.stale}, 8'h00);
    chk("race_fv", {7'b0, if0.feat_valid}, 8'h01);

    drive(1, 40, 5, 60);
    drive(1, 40, 5, 60);
    settle();
    @(negedge clk);
    set_inputs(1, 40, 5, 60);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_accel", if0.accel, 8'h00);
    chk("arst_steer", if0.steer, 8'h00);
    chk("arst_brake", if0.brake, 8'h00);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, 40, 5, 60);
      settle();
      chk("rewarm_fv", {7'b0, if0.feat_valid}, (i == 4) ? 8'h01 : 8'h00);
    end

    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(19) == 0) begin
        repeat ($urandom_range(18, 14)) drive(0, 0, 0, 0);
      end else begin
        drive($urandom_range(3) != 0,
              int'($urandom_range(255)) - 128,
              int'($urandom_range(255)) - 128,
              int'($urandom_range(255)));
      end
    end
    drive(0, 0, 0, 0);
    settle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
